// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: state encoding, default width and
// the DIV/DIVU funct codes the main decoder already uses.
package div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left, trial
// subtract the divisor and keep the difference when it does not go negative.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    // rem < divisor on entry, so WIDTH+1 bits hold the shifted value and the trial sign
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, i_divisor};

    assign o_rem = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU with start/done handshake and annul.
// Define DIV_ZERO_FAST_EN to finish a divide-by-zero in one cycle instead of WIDTH+1.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             annul,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);

    localparam logic [CNT_W-1:0] LastStep = CNT_W'(WIDTH - 1);

    div_state_e       r_state;
    div_state_e       w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_qsign;
    logic             r_rsign;
    logic             r_dz;

    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_opb_zero;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_final_lo;
    logic [WIDTH-1:0] w_final_hi;
    logic             w_load;
    logic             w_step;
    logic             w_commit;

    assign w_neg_a    = signed_div & opa[WIDTH-1];
    assign w_neg_b    = signed_div & opb[WIDTH-1];
    assign w_abs_a    = w_neg_a ? -opa : opa;
    assign w_abs_b    = w_neg_b ? -opb : opb;
    assign w_opb_zero = (opb == '0);

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem    (r_rem),
        .i_quo    (r_quo),
        .i_divisor(r_divisor),
        .o_rem    (w_rem_nxt),
        .o_quo    (w_quo_nxt)
    );

    // r_quo/r_rem hold the final magnitudes in DONE, so results are formed from them directly
    assign w_final_lo = r_dz ? '1    : (r_qsign ? -r_quo : r_quo);
    assign w_final_hi = r_dz ? r_opa : (r_rsign ? -r_rem : r_rem);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_load    = 1'b0;
        w_step    = 1'b0;
        w_commit  = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (start && !annul) begin
                    w_load = 1'b1;
`ifdef DIV_ZERO_FAST_EN
                    w_state_d = w_opb_zero ? DIV_DONE : DIV_BUSY;
`else
                    w_state_d = DIV_BUSY;
`endif
                end
            end
            DIV_BUSY: begin
                if (annul) begin
                    w_state_d = DIV_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == LastStep) begin
                        w_state_d = DIV_DONE;
                    end
                end
            end
            DIV_DONE: begin
                w_state_d = DIV_IDLE;
                w_commit  = !annul;
            end
            default: w_state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_opa     <= '0;
            r_qsign   <= 1'b0;
            r_rsign   <= 1'b0;
            r_dz      <= 1'b0;
            r_lo      <= '0;
            r_hi      <= '0;
        end else begin
            if (w_load) begin
                r_cnt     <= '0;
                r_rem     <= '0;
                r_quo     <= w_abs_a;
                r_divisor <= w_abs_b;
                r_opa     <= opa;
                r_qsign   <= w_neg_a ^ w_neg_b;
                r_rsign   <= w_neg_a;
                r_dz      <= w_opb_zero;
            end else if (w_step) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_commit) begin
                r_lo <= w_final_lo;
                r_hi <= w_final_hi;
            end
        end
    end

    assign busy = (r_state != DIV_IDLE);
    assign done = (r_state == DIV_DONE) && !annul;

    // New results are visible in the done cycle itself; an annul there keeps the old ones
    assign result_lo = done ? w_final_lo : r_lo;
    assign result_hi = done ? w_final_hi : r_hi;

endmodule
